text_char_buffer: RTL and testbench
===================================

# text_char_buffer

Parametrised character store for the text-drawing path. It holds DEPTH character codes that the glyph renderer reads by index. Writes come from three sources: direct addressed writes, cursor-based append and backspace, and a sequenced clear that fills every entry with FILL_CHAR. It also reports the current text length and buffer state to the controlling logic.

## Interface
- CHAR_W, 7, character code width in bits
- DEPTH, 8, number of character entries (≥2); AW = $clog2(DEPTH) is a derived local
- FILL_CHAR, 7'h20, value written by clear/backspace and returned for out-of-range reads
- Clk  in  1  single clock, all state on rising edge
- Reset  in  1  asynchronous, active-high
- wr_en  in  1  direct write strobe
- wr_addr  in  AW  direct write index
- wr_data  in  CHAR_W  direct write data
- app_en  in  1  append wr_data... no: append strobe, data on app_data
- app_data  in  CHAR_W  append character
- bksp  in  1  backspace strobe
- clr_req  in  1  start full-buffer clear
- rd_addr  in  AW  read index (renderer)
- rd_data  out  CHAR_W  registered read data
- length  out  AW+1  characters appended (= cursor position), 0..DEPTH
- full  out  1  length == DEPTH
- busy  out  1  clear sequence in progress
- clr_done  out  1  one-cycle pulse at clear completion
- overflow  out  1  one-cycle pulse: append refused because full

## Operation
- FSM: IDLE, CLEAR. Clear pointer ptr (AW bits).
- Reset asserted: state=CLEAR, ptr=0, length=0, rd_data=FILL_CHAR, busy=1, clr_done=0, overflow=0. Memory is not reset directly; it is cleared by the CLEAR sequence that runs after Reset deasserts.
- CLEAR: each edge writes FILL_CHAR to mem[ptr] and increments ptr. At ptr==DEPTH-1 the write completes, state→IDLE, clr_done=1 for the next cycle. While in CLEAR, wr_en/app_en/bksp/clr_req are ignored and do not produce overflow.
- IDLE, per edge, priority clr_req > bksp > app_en > wr_en (one action per cycle; lower-priority strobes in the same cycle are dropped):
  - clr_req: state→CLEAR, ptr=0, length=0. The first fill happens on the next edge.
  - bksp: if length>0, mem[length-1]<=FILL_CHAR, length--. If length==0, no effect.
  - app_en: if !full, mem[length]<=app_data, length++. If full, no write and overflow=1 for one cycle.
  - wr_en: mem[wr_addr]<=wr_data; length unchanged. A wr_addr ≥ DEPTH is ignored.
- Read: each edge, rd_data<=mem[rd_addr], or FILL_CHAR if rd_addr ≥ DEPTH. Reads are read-before-write: a same-edge write to the same index returns the old value.
- full and busy are combinational from state/length. clr_done and overflow are registered pulses.

## Timing
- Read latency 1 cycle. Reads are valid during CLEAR and return the partially cleared contents.
- Clear: clr_req sampled at edge N → busy=1 after N. Fills occur at edges N+1..N+DEPTH. busy=0 and clr_done=1 after edge N+DEPTH; clr_done=0 after N+DEPTH+1. Total DEPTH+1 cycles from request to IDLE.
- After Reset deasserts: fills occur at the first DEPTH edges, then IDLE with clr_done pulse. A Reset during a clear restarts it at ptr=0.
- Append/backspace/write take effect at the sampling edge. length/full update at the same edge, so an append in the cycle after reaching full overflows.
- Back-to-back app_en every cycle is supported at full rate.

## Test plan
- Reset release, DEPTH=8: busy=1 for exactly 8 edges, then clr_done pulses once; all rd_addr 0..7 return 7'h20 one cycle after presentation.
- Append 'a'..'h' (7'h61..7'h68) consecutively: length 1..8, full=1 after 8th; a 9th append produces overflow=1 for one cycle, and mem[7] stays 7'h68.
- Backspace twice from length 8: length=6, entries 6,7 read 7'h20, entry 5 reads 7'h66; backspace at length 0 leaves length 0.
- Same cycle app_en+wr_en+bksp at length 3: only backspace occurs (length 2). Same-edge rd_addr=wr_addr write returns old data, then new data on the following read.
- clr_req with app_en held high throughout the clear: no writes or overflow during busy, 9 cycles to IDLE, length=0; the append in the first IDLE cycle lands at index 0.
- Reset asserted mid-clear (ptr=4): outputs take reset values immediately; the clear restarts and lasts a full 8 edges.

Source files
------------

// File: rtl/text_char_buffer_if.sv
// Port bundle for text_char_buffer: write/append/backspace/clear controls,
// renderer read port, and status back to the controlling logic.
interface text_char_buffer_if #(
    parameter int CHAR_W = 7,
    parameter int DEPTH  = 8
);
    localparam int AW = $clog2(DEPTH);

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [CHAR_W-1:0] wr_data;
    logic              app_en;
    logic [CHAR_W-1:0] app_data;
    logic              bksp;
    logic              clr_req;
    logic [AW-1:0]     rd_addr;
    logic [CHAR_W-1:0] rd_data;
    logic [AW:0]       length;
    logic              full;
    logic              busy;
    logic              clr_done;
    logic              overflow;

    modport master (
        output wr_en, wr_addr, wr_data, app_en, app_data, bksp, clr_req, rd_addr,
        input  rd_data, length, full, busy, clr_done, overflow
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, app_en, app_data, bksp, clr_req, rd_addr,
        output rd_data, length, full, busy, clr_done, overflow
    );
endinterface

// File: rtl/text_char_buffer.sv
// Character store for the text-drawing path: addressed writes, cursor append/backspace,
// sequenced fill-clear, and a registered read port for the glyph renderer.
module text_char_buffer #(
    parameter int                 CHAR_W    = 7,
    parameter int                 DEPTH     = 8,
    parameter logic [CHAR_W-1:0]  FILL_CHAR = 7'h20
) (
    input  logic               Clk,
    input  logic               Reset,
    text_char_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_P  = AW'(DEPTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]        state;
    logic [AW-1:0]     ptr;
    logic [AW:0]       length;
    logic              clr_done;
    logic              overflow;
    logic [CHAR_W-1:0] rd_data;
    logic [CHAR_W-1:0] mem [DEPTH];

    logic              full;
    logic              busy;
    logic [AW:0]       length_dec;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [CHAR_W-1:0] mem_wdata;

    assign full       = (length == DEPTH_L);
    assign busy       = (state == ST_CLEAR);
    assign length_dec = length - (AW+1)'(1);

    assign bus.rd_data  = rd_data;
    assign bus.length   = length;
    assign bus.full     = full;
    assign bus.busy     = busy;
    assign bus.clr_done = clr_done;
    assign bus.overflow = overflow;

    // Single write port; the clear sequence owns it, otherwise one action by priority.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = FILL_CHAR;
        if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr;
        end else if (bus.clr_req) begin
            mem_we    = 1'b0;
        end else if (bus.bksp) begin
            if (length != '0) begin
                mem_we    = 1'b1;
                mem_waddr = length_dec[AW-1:0];
            end
        end else if (bus.app_en) begin
            if (!full) begin
                mem_we    = 1'b1;
                mem_waddr = length[AW-1:0];
                mem_wdata = bus.app_data;
            end
        end else if (bus.wr_en) begin
            if ({1'b0, bus.wr_addr} < DEPTH_L) begin
                mem_we    = 1'b1;
                mem_waddr = bus.wr_addr;
                mem_wdata = bus.wr_data;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read-before-write: the array read sees the value prior to this edge's write.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_data <= FILL_CHAR;
        end else if ({1'b0, bus.rd_addr} < DEPTH_L) begin
            rd_data <= mem[bus.rd_addr];
        end else begin
            rd_data <= FILL_CHAR;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= ST_CLEAR;
            ptr      <= '0;
            length   <= '0;
            clr_done <= 1'b0;
            overflow <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            overflow <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (ptr == LAST_P) begin
                        state    <= ST_IDLE;
                        ptr      <= '0;
                        clr_done <= 1'b1;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
                default: begin
                    if (bus.clr_req) begin
                        state  <= ST_CLEAR;
                        ptr    <= '0;
                        length <= '0;
                    end else if (bus.bksp) begin
                        if (length != '0) begin
                            length <= length_dec;
                        end
                    end else if (bus.app_en) begin
                        if (!full) begin
                            length <= length + (AW+1)'(1);
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_text_char_buffer.sv
// Directed bench for text_char_buffer (DEPTH=8): reset clear, append/overflow,
// backspace, strobe priority, read-before-write, clear with held append, reset mid-clear.
module tb_text_char_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    text_char_buffer_if #(.CHAR_W(7), .DEPTH(8)) bus ();

    text_char_buffer #(.CHAR_W(7), .DEPTH(8), .FILL_CHAR(7'h20)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, input logic [6:0] exp, input string tag);
        bus.rd_addr = a;
        tick();
        check(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.app_en = 1'b0; bus.app_data = '0; bus.bksp = 1'b0;
        bus.clr_req = 1'b0; bus.rd_addr = '0;

        // Reset state
        tick(); tick();
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_length", 32'(bus.length), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'h20);
        check("rst_clr_done", 32'(bus.clr_done), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);

        // Post-reset clear: 8 edges busy, then one clr_done pulse
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("init_busy", 32'(bus.busy), 32'd1);
            check("init_done_low", 32'(bus.clr_done), 32'd0);
            tick();
        end
        check("init_idle", 32'(bus.busy), 32'd0);
        check("init_done_pulse", 32'(bus.clr_done), 32'd1);
        tick();
        check("init_done_end", 32'(bus.clr_done), 32'd0);
        for (int a = 0; a < 8; a++) rd(3'(a), 7'h20, "init_fill");

        // Append 'a'..'h', then overflow
        for (int i = 0; i < 8; i++) begin
            bus.app_en = 1'b1;
            bus.app_data = 7'(7'h61 + i);
            tick();
            check("app_length", 32'(bus.length), 32'(i + 1));
            check("app_full", 32'(bus.full), (i == 7) ? 32'd1 : 32'd0);
        end
        bus.app_data = 7'h69;
        tick();
        check("ovf_pulse", 32'(bus.overflow), 32'd1);
        check("ovf_length", 32'(bus.length), 32'd8);
        bus.app_en = 1'b0;
        tick();
        check("ovf_end", 32'(bus.overflow), 32'd0);
        rd(3'd7, 7'h68, "ovf_mem7");
        rd(3'd0, 7'h61, "app_mem0");

        // Backspace twice
        bus.bksp = 1'b1;
        tick();
        check("bksp_len7", 32'(bus.length), 32'd7);
        check("bksp_notfull", 32'(bus.full), 32'd0);
        tick();
        check("bksp_len6", 32'(bus.length), 32'd6);
        bus.bksp = 1'b0;
        rd(3'd6, 7'h20, "bksp_mem6");
        rd(3'd7, 7'h20, "bksp_mem7");
        rd(3'd5, 7'h66, "bksp_mem5");

        // Backspace down to zero and once more
        bus.bksp = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("bksp_len0", 32'(bus.length), 32'd0);
        tick();
        check("bksp_at0", 32'(bus.length), 32'd0);
        bus.bksp = 1'b0;

        // Strobe priority at length 3
        for (int i = 0; i < 3; i++) begin
            bus.app_en = 1'b1;
            bus.app_data = 7'(7'h78 + i);
            tick();
        end
        check("pri_len3", 32'(bus.length), 32'd3);
        bus.app_data = 7'h33;
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 7'h11;
        bus.bksp = 1'b1;
        tick();
        bus.app_en = 1'b0; bus.wr_en = 1'b0; bus.bksp = 1'b0;
        check("pri_len2", 32'(bus.length), 32'd2);
        check("pri_no_ovf", 32'(bus.overflow), 32'd0);
        rd(3'd2, 7'h20, "pri_bksp_mem2");
        rd(3'd0, 7'h78, "pri_wr_dropped");
        rd(3'd3, 7'h20, "pri_app_dropped");

        // Read-before-write on same index
        bus.rd_addr = 3'd1;
        bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 7'h55;
        tick();
        bus.wr_en = 1'b0;
        check("rbw_old", 32'(bus.rd_data), 32'h79);
        tick();
        check("rbw_new", 32'(bus.rd_data), 32'h55);
        check("wr_len_same", 32'(bus.length), 32'd2);

        // Clear with app_en held high throughout
        bus.clr_req = 1'b1;
        bus.app_en = 1'b1; bus.app_data = 7'h41;
        tick();
        bus.clr_req = 1'b0;
        check("clr_busy", 32'(bus.busy), 32'd1);
        check("clr_len0", 32'(bus.length), 32'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("clr_hold_busy", 32'(bus.busy), 32'd1);
            check("clr_hold_len", 32'(bus.length), 32'd0);
            check("clr_hold_ovf", 32'(bus.overflow), 32'd0);
        end
        tick();
        check("clr_idle", 32'(bus.busy), 32'd0);
        check("clr_done_pulse", 32'(bus.clr_done), 32'd1);
        check("clr_idle_len", 32'(bus.length), 32'd0);
        tick();
        bus.app_en = 1'b0;
        check("clr_first_app_len", 32'(bus.length), 32'd1);
        check("clr_done_end", 32'(bus.clr_done), 32'd0);
        rd(3'd0, 7'h41, "clr_app_idx0");
        rd(3'd1, 7'h20, "clr_mem1");

        // Reset during a clear at ptr=4
        bus.wr_en = 1'b1; bus.wr_addr = 3'd7; bus.wr_data = 7'h5a;
        tick();
        bus.wr_en = 1'b0;
        rd(3'd7, 7'h5a, "mid_pre_mem7");
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_busy", 32'(bus.busy), 32'd1);
        check("mid_rd_partial", 32'(bus.rd_data), 32'h5a);
        rst = 1'b1;
        #1;
        check("mid_rst_rd", 32'(bus.rd_data), 32'h20);
        check("mid_rst_len", 32'(bus.length), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd1);
        check("mid_rst_done", 32'(bus.clr_done), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("restart_busy", 32'(bus.busy), 32'd1);
            tick();
        end
        check("restart_idle", 32'(bus.busy), 32'd0);
        check("restart_done", 32'(bus.clr_done), 32'd1);
        rd(3'd7, 7'h20, "restart_mem7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
